// File: rtl/fetch_queue.sv
// Prefetching instruction fetch stage. Sequential fetches are pushed into a
// DEPTH-entry queue ahead of decode; a redirect from Execute flushes the queue
// and restarts fetching at the target.
module fetch_queue #(
    parameter int unsigned            XLEN      = 32,
    parameter int unsigned            DEPTH     = 4,
    parameter logic [XLEN-1:0]        RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]        NOP_INSTR = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      PCSrc,
    input  logic [XLEN-1:0]           PCTarget,
    input  logic                      StallD,
    output logic                      imem_req,
    output logic [XLEN-1:0]           imem_addr,
    input  logic                      imem_gnt,
    input  logic [XLEN-1:0]           imem_rdata,
    output logic                      instr_valid,
    output logic [XLEN-1:0]           instr,
    output logic [XLEN-1:0]           instr_pc,
    output logic [XLEN-1:0]           instr_pcplus4,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic push;
    logic pop;
    logic empty;
    logic full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Request and handshake decode; imem_req is the only output with a
    // combinational path from inputs (reset and PCSrc).
    always_comb begin
        imem_req = reset && !PCSrc && !full;
        push     = imem_req && imem_gnt;
        pop      = !empty && !StallD && !PCSrc;
    end

    // Next-state for fetch PC, pointers and occupancy. Redirect flushes and
    // suppresses push/pop for the cycle.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (PCSrc) begin
            fetch_pc_d = {PCTarget[XLEN-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                wr_ptr_d   = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents need no reset since occupancy gates the outputs.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
        end
    end

    // Head outputs from registered state; empty values when nothing is queued.
    always_comb begin
        instr_valid   = !empty;
        instr         = NOP_INSTR;
        instr_pc      = '0;
        instr_pcplus4 = '0;
        if (!empty) begin
            instr         = instr_mem[rd_ptr_q];
            instr_pc      = pc_mem[rd_ptr_q];
            instr_pcplus4 = pc_mem[rd_ptr_q] + XLEN'(4);
        end
    end

    assign imem_addr = fetch_pc_q;
    assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory returns the address as the word, so
// every head entry must satisfy instr == instr_pc.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        StallD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_pc;

    fetch_queue dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc         (PCSrc),
        .PCTarget      (PCTarget),
        .StallD        (StallD),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pcplus4 (instr_pcplus4),
        .count         (count)
    );

    assign imem_rdata = imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_count"}, {29'd0, count}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, 32'h13);
        chk({tag, "_pc"}, instr_pc, 32'd0);
        chk({tag, "_pc4"}, instr_pcplus4, 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        PCSrc    = 1'b0;
        PCTarget = 32'd0;
        StallD   = 1'b1;
        imem_gnt = 1'b0;

        // Reset for two edges
        tick();
        tick();
        chk_empty("rst");
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);

        // Fill with decode stalled
        reset    = 1'b1;
        imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fill_addr", imem_addr, 32'(4 * i));
            chk("fill_req", {31'd0, imem_req}, 32'd1);
            tick();
            chk("fill_count", {29'd0, count}, 32'(i + 1));
        end
        chk("full_req", {31'd0, imem_req}, 32'd0);
        chk("full_instr", instr, 32'h0);
        chk("full_pc", instr_pc, 32'h0);
        chk("full_pc4", instr_pcplus4, 32'h4);
        chk("full_addr", imem_addr, 32'h10);

        // Stream 3*DEPTH instructions across pointer wrap
        StallD = 1'b0;
        exp_pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("stream_valid", {31'd0, instr_valid}, 32'd1);
            chk("stream_pc", instr_pc, exp_pc);
            chk("stream_instr", instr, exp_pc);
            tick();
            exp_pc = exp_pc + 32'd4;
            if (i == 0) begin
                chk("resume_addr", imem_addr, 32'h10);
                chk("resume_req", {31'd0, imem_req}, 32'd1);
                chk("resume_count", {29'd0, count}, 32'd3);
            end
        end
        chk("stream_end_count", {29'd0, count}, 32'd3);
        chk("stream_end_pc", instr_pc, 32'h30);
        chk("stream_end_addr", imem_addr, 32'h3C);

        // Redirect with count=3
        StallD   = 1'b1;
        PCSrc    = 1'b1;
        PCTarget = 32'h27;
        #1;
        chk("redir_req", {31'd0, imem_req}, 32'd0);
        tick();
        PCSrc = 1'b0;
        #1;
        chk_empty("redir");
        chk("redir_addr", imem_addr, 32'h24);
        chk("redir_req_after", {31'd0, imem_req}, 32'd1);
        tick();
        chk("redir_first_pc", instr_pc, 32'h24);
        chk("redir_first_count", {29'd0, count}, 32'd1);

        // Memory wait at 0x8
        PCSrc    = 1'b1;
        PCTarget = 32'h8;
        tick();
        PCSrc    = 1'b0;
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr", imem_addr, 32'h8);
            chk("wait_count", {29'd0, count}, 32'd0);
        end
        imem_gnt = 1'b1;
        tick();
        chk("wait_push_count", {29'd0, count}, 32'd1);
        chk("wait_push_pc", instr_pc, 32'h8);
        chk("wait_push_addr", imem_addr, 32'hC);
        tick();
        chk("wait_push2_count", {29'd0, count}, 32'd2);
        chk("wait_push2_head", instr_pc, 32'h8);

        // Simultaneous push and pop at count=2
        StallD = 1'b0;
        exp_pc = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            chk("pp_count", {29'd0, count}, 32'd2);
            chk("pp_head", instr_pc, exp_pc);
        end
        chk("pp_addr", imem_addr, 32'h1C);

        // Empty queue with StallD=0: no pop
        PCSrc    = 1'b1;
        PCTarget = 32'h34;
        tick();
        PCSrc    = 1'b0;
        imem_gnt = 1'b0;
        tick();
        chk_empty("empty_nostall");
        chk("empty_addr", imem_addr, 32'h34);

        // Build count=3 with fetch PC 0x40, then reset mid-stream
        StallD   = 1'b1;
        imem_gnt = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        chk("pre_rst_addr", imem_addr, 32'h40);
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk_empty("mid_rst");
        chk("mid_rst_addr", imem_addr, 32'h0);
        tick();
        chk("post_rst_pc", instr_pc, 32'h0);
        chk("post_rst_count", {29'd0, count}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor of the single-PC fetch unit: a prefetching instruction fetch stage with a DEPTH-entry queue between instruction memory and decode.
- Issues sequential fetches ahead of decode, absorbs decode stalls without stalling memory, and flushes the queue on a branch/jump redirect from Execute.
- Sits between instruction memory and the IF/ID pipeline register. The queue replaces StallF-driven PC holding.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- DEPTH, 4, queue entries; power of 2, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr while the queue is empty.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- PCSrc  in  1  redirect request from Execute (taken branch/jump).
- PCTarget  in  XLEN  redirect address; bits [1:0] ignored and forced to 0.
- StallD  in  1  decode not ready; head entry held when 1.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address (current fetch PC).
- imem_gnt  in  1  memory accepts request; imem_rdata valid in the same cycle.
- imem_rdata  in  XLEN  instruction word for imem_addr.
- instr_valid  out  1  head entry present.
- instr  out  XLEN  head instruction; NOP_INSTR when empty.
- instr_pc  out  XLEN  PC of head instruction; 0 when empty.
- instr_pcplus4  out  XLEN  instr_pc + 4, computed modulo 2^XLEN; 0 when empty.
- count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset==0 at an edge):
  - fetch PC = RESET_PC; count = 0; read and write pointers = 0.
  - Resulting outputs: instr_valid=0, instr=NOP_INSTR, instr_pc=0, instr_pcplus4=0, imem_addr=RESET_PC.
  - imem_req=0 while reset is low.
  - Reset asserted mid-stream discards all entries and any pending fetch at that edge.
- Request: imem_req = reset && !PCSrc && (count < DEPTH). imem_addr = fetch PC at all times.
- Push: occurs when imem_req && imem_gnt.
  - Writes {imem_rdata, fetch PC} at the write pointer.
  - Fetch PC += 4 (wraps modulo 2^XLEN); write pointer increments modulo DEPTH.
- Stalled memory: if imem_gnt=0 with imem_req=1, fetch PC and imem_addr hold.
- Pop: occurs when instr_valid && !StallD && !PCSrc; read pointer increments modulo DEPTH.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged.
- Latency: a word accepted at edge N is visible at the head after edge N (earliest cycle N+1). There is no combinational bypass from imem_rdata to instr, even when the queue is empty.
- Full (count==DEPTH): imem_req=0, even if a pop occurs that cycle. The one-cycle refill bubble is accepted.
- Empty (count==0): instr_valid=0 and outputs take their empty values. StallD is ignored.
- Redirect (PCSrc=1 at an edge):
  - count=0, pointers=0, fetch PC = {PCTarget[XLEN-1:2], 2'b00}.
  - No push and no pop that cycle.
  - Redirect takes priority over push, pop and stall.
  - First fetch from the target is issued in the following cycle.
- Priority order: reset, then PCSrc, then push/pop.
- Outputs are driven from registered state only. The sole exception is imem_req, which is combinational on PCSrc and reset.

Test Plan:
- Fill: reset low 2 cycles; then imem_gnt=1, StallD=1, memory word = address. Required: imem_addr 0x0, 0x4, 0x8, 0xC on consecutive cycles; count reaches 4; imem_req=0 from the 5th cycle; instr=0x0, instr_pc=0x0, instr_pcplus4=0x4.
- Stream: from full, release StallD. Required: head pc sequence 0x0, 0x4, 0x8, ... with instr == pc; fetches resume at 0x10; no entry duplicated or skipped across pointer wrap (run 3×DEPTH instructions).
- Redirect: count=3, pulse PCSrc=1, PCTarget=0x27 for 1 cycle. Required next cycle: count=0, instr_valid=0, instr=0x13, imem_addr=0x24, and imem_req=0 during the PCSrc cycle. One cycle later: instr_pc=0x24.
- Memory wait: imem_gnt=0 for 3 cycles at address 0x8. Required: imem_addr holds 0x8 and count does not increase; on imem_gnt=1, 0x8 is pushed exactly once.
- Simultaneous push/pop at count=2 with StallD=0, imem_gnt=1. Required: count stays 2 and head advances by 4 each cycle. Empty queue with StallD=0: no pop, count stays 0.
- Reset mid-stream: reset=0 for one edge with count=3 and fetch PC 0x40. Required: count=0, instr_valid=0, imem_addr=RESET_PC; the first fetch after reset is RESET_PC.
